// File: rtl/fetch_prefetch_queue.sv
// Fetch stage with one outstanding AXI read and a DEPTH-entry {pc, inst} prefetch queue feeding ID.
// Optional build macro FETCH_PERF_EN adds perf_fetched, perf_flushed and perf_empty_stall counters.
module fetch_prefetch_queue #(
   parameter int                ADDR_W     = 32,
   parameter int                INST_W     = 32,
   parameter int                DEPTH      = 4,
   parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     IF_valid,
   input  logic                     next_fetch,
   input  logic [ADDR_W:0]          jbr_bus,
   input  logic [ADDR_W:0]          exc_bus,
   output logic                     axi_start,
   output logic [ADDR_W-1:0]        axi_addr,
   input  logic                     axi_done,
   input  logic [INST_W-1:0]        axi_rdata,
   input  logic                     axi_busy,
   output logic                     IF_over,
   output logic [ADDR_W+INST_W-1:0] IF_ID_bus,
   output logic [ADDR_W-1:0]        IF_pc,
   output logic [INST_W-1:0]        IF_inst,
   output logic [$clog2(DEPTH):0]   q_count
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]              perf_fetched,
   output logic [31:0]              perf_flushed,
   output logic [31:0]              perf_empty_stall
`endif
);

   localparam int               PTR_W = $clog2(DEPTH);
   localparam int               CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [ADDR_W-1:0]          r_fetch_pc;
   logic [ADDR_W-1:0]          r_axi_addr;
   logic [ADDR_W-1:0]          r_req_pc;
   logic                       r_discard;
   logic [ADDR_W+INST_W-1:0]   r_mem [DEPTH];
   logic [PTR_W-1:0]           r_wr_ptr;
   logic [PTR_W-1:0]           r_rd_ptr;
   logic [CNT_W-1:0]           r_count;

   logic                       w_redirect;
   logic [ADDR_W-1:0]          w_target;
   logic                       w_issue;
   logic                       w_done;
   logic                       w_push;
   logic                       w_pop;

   // Exception outranks branch when both redirect in the same cycle.
   assign w_redirect = exc_bus[ADDR_W] | jbr_bus[ADDR_W];
   assign w_target   = exc_bus[ADDR_W] ? exc_bus[ADDR_W-1:0] : jbr_bus[ADDR_W-1:0];

   // Only issued from IDLE, so nothing is in flight and a free slot is all that is needed.
   assign w_issue = IF_valid && !axi_busy && (r_count < FULL) && !w_redirect;
   assign w_done  = (r_state == S_WAIT) && axi_done;
   assign w_push  = w_done && !r_discard && !w_redirect;
   assign w_pop   = (r_count != '0) && next_fetch && !w_redirect;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_issue) w_state_nxt = S_REQ;
         S_REQ:   w_state_nxt = S_WAIT;
         S_WAIT:  if (axi_done) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_pc <= START_ADDR;
         r_axi_addr <= START_ADDR;
         r_req_pc   <= START_ADDR;
         r_discard  <= 1'b0;
      end else begin
         if (r_state == S_IDLE && w_issue) begin
            r_axi_addr <= r_fetch_pc;
            r_req_pc   <= r_fetch_pc;
         end
         if (w_redirect)            r_fetch_pc <= w_target;
         else if (r_state == S_REQ) r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
         // A response consumed together with a redirect is simply dropped; discard only covers later ones.
         if (w_done)
            r_discard <= 1'b0;
         else if (w_redirect && (r_state == S_REQ || r_state == S_WAIT))
            r_discard <= 1'b1;
      end
   end

   // NOTE: queue storage is not reset; r_count alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {r_req_pc, axi_rdata};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (w_redirect) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      end
   end

   assign axi_start = (r_state == S_REQ);
   assign axi_addr  = r_axi_addr;
   assign IF_over   = (r_count != '0);
   assign IF_ID_bus = IF_over ? r_mem[r_rd_ptr] : '0;
   assign IF_pc     = IF_ID_bus[ADDR_W+INST_W-1:INST_W];
   assign IF_inst   = IF_ID_bus[INST_W-1:0];
   assign q_count   = r_count;

`ifdef FETCH_PERF_EN
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_flushed;
   logic [31:0] r_perf_empty_stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_perf_fetched     <= '0;
         r_perf_flushed     <= '0;
         r_perf_empty_stall <= '0;
      end else begin
         if (w_push)               r_perf_fetched     <= r_perf_fetched + 32'd1;
         if (w_redirect)           r_perf_flushed     <= r_perf_flushed + 32'd1;
         if (!IF_over && IF_valid) r_perf_empty_stall <= r_perf_empty_stall + 32'd1;
      end
   end

   assign perf_fetched     = r_perf_fetched;
   assign perf_flushed     = r_perf_flushed;
   assign perf_empty_stall = r_perf_empty_stall;
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: AXI slave model plus a transaction-level queue reference model.
// Build with FETCH_PERF_EN defined to also check the performance counters.
module tb_fetch_prefetch_queue;

   localparam int          ADDR_W = 32;
   localparam int          INST_W = 32;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] START  = 32'h0000_0000;
   localparam logic [31:0] KEY    = 32'hA5A5_A5A5;
   localparam int          TMO    = 200;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   logic        clk        = 1'b0;
   logic        reset      = 1'b1;
   logic        IF_valid   = 1'b0;
   logic        next_fetch = 1'b0;
   logic [32:0] jbr_bus    = '0;
   logic [32:0] exc_bus    = '0;
   logic        axi_done   = 1'b0;
   logic [31:0] axi_rdata  = '0;
   logic        axi_busy   = 1'b0;
   logic        axi_start;
   logic [31:0] axi_addr;
   logic        IF_over;
   logic [63:0] IF_ID_bus;
   logic [31:0] IF_pc;
   logic [31:0] IF_inst;
   logic [2:0]  q_count;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_flushed;
   logic [31:0] perf_empty_stall;
   logic [31:0] exp_fetched;
   logic [31:0] exp_flushed;
   logic [31:0] exp_stall;
`endif

   fetch_prefetch_queue #(
      .ADDR_W    (ADDR_W),
      .INST_W    (INST_W),
      .DEPTH     (DEPTH),
      .START_ADDR(START)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .IF_valid  (IF_valid),
      .next_fetch(next_fetch),
      .jbr_bus   (jbr_bus),
      .exc_bus   (exc_bus),
      .axi_start (axi_start),
      .axi_addr  (axi_addr),
      .axi_done  (axi_done),
      .axi_rdata (axi_rdata),
      .axi_busy  (axi_busy),
      .IF_over   (IF_over),
      .IF_ID_bus (IF_ID_bus),
      .IF_pc     (IF_pc),
      .IF_inst   (IF_inst),
      .q_count   (q_count)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched    (perf_fetched),
      .perf_flushed    (perf_flushed),
      .perf_empty_stall(perf_empty_stall)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: queued entries, next expected request pc, one outstanding request.
   entry_t      mq[$];
   logic [31:0] exp_pc = START;
   bit          out_live;
   logic [31:0] out_pc;
   // AXI slave model.
   bit          sl_pend;
   int          sl_rem;
   int          sl_tail;
   int          lat = 2;
   bit          rand_tail;
   // Stimulus for the next cycle and observations of the current one.
   logic        d_valid = 1'b0;
   logic        d_next  = 1'b0;
   logic        d_busy  = 1'b0;
   logic [32:0] d_jbr   = '0;
   logic [32:0] d_exc   = '0;
   bit          s_start;
   logic [31:0] s_addr;
   bit          s_done;
   logic [31:0] addr_log[$];
   int          n_starts;
   int          n_checks;
   int          n_fail;

   // One clock cycle: check outputs against the model, drive inputs, advance the model.
   task automatic step();
      logic        busy_now;
      logic        done_now;
      logic [31:0] rdata_now;
      logic        redir;
      logic [31:0] tgt;
      @(negedge clk);
      n_checks++;
      if (IF_over !== (mq.size() != 0)) begin
         n_fail++;
         $display("FAIL if_over: got %b expected %b", IF_over, mq.size() != 0);
      end
      n_checks++;
      if (q_count !== 3'(mq.size())) begin
         n_fail++;
         $display("FAIL q_count: got %0d expected %0d", q_count, mq.size());
      end
      if (mq.size() != 0) begin
         n_checks++;
         if (IF_ID_bus !== mq[0] || IF_pc !== mq[0].pc || IF_inst !== mq[0].inst) begin
            n_fail++;
            $display("FAIL head_entry: got %h expected %h", IF_ID_bus, mq[0]);
         end
      end
`ifdef FETCH_PERF_EN
      n_checks++;
      if (perf_fetched !== exp_fetched || perf_flushed !== exp_flushed || perf_empty_stall !== exp_stall) begin
         n_fail++;
         $display("FAIL perf: got %0d/%0d/%0d expected %0d/%0d/%0d", perf_fetched, perf_flushed,
                  perf_empty_stall, exp_fetched, exp_flushed, exp_stall);
      end
`endif
      s_start  = axi_start;
      s_addr   = axi_addr;
      busy_now = d_busy | sl_pend | (sl_tail > 0);
      if (sl_tail > 0) sl_tail--;
      done_now  = 1'b0;
      rdata_now = $urandom();
      if (sl_pend) begin
         sl_rem--;
         if (sl_rem == 0) begin
            done_now  = 1'b1;
            sl_pend   = 1'b0;
            rdata_now = out_pc ^ KEY;
            if (rand_tail) sl_tail = $urandom_range(0, 2);
         end
      end
      if (s_start) begin
         n_checks++;
         if (s_addr !== exp_pc) begin
            n_fail++;
            $display("FAIL axi_addr: got %h expected %h", s_addr, exp_pc);
         end
         n_checks++;
         if (busy_now || mq.size() >= DEPTH) begin
            n_fail++;
            $display("FAIL illegal_start: busy=%b entries=%0d limit %0d", busy_now, mq.size(), DEPTH);
         end
         addr_log.push_back(s_addr);
         n_starts++;
         sl_pend  = 1'b1;
         sl_rem   = lat;
         out_pc   = s_addr;
         out_live = 1'b1;
         exp_pc   = s_addr + 32'd4;
      end
      redir = d_exc[32] | d_jbr[32];
      tgt   = d_exc[32] ? d_exc[31:0] : d_jbr[31:0];
      IF_valid   = d_valid;
      next_fetch = d_next;
      jbr_bus    = d_jbr;
      exc_bus    = d_exc;
      axi_busy   = busy_now;
      axi_done   = done_now;
      axi_rdata  = rdata_now;
`ifdef FETCH_PERF_EN
      if (mq.size() == 0 && d_valid) exp_stall++;
      if (redir) exp_flushed++;
      if (done_now && out_live && !redir) exp_fetched++;
`endif
      if (mq.size() != 0 && d_next && !redir) void'(mq.pop_front());
      if (done_now && out_live && !redir) mq.push_back({out_pc, rdata_now});
      if (done_now) out_live = 1'b0;
      if (redir) begin
         mq.delete();
         out_live = 1'b0;
         exp_pc   = tgt;
      end
      s_done = done_now;
   endtask

   // Asynchronous reset mid-cycle; outputs must return to reset values without a clock edge.
   task automatic do_reset();
      @(negedge clk);
      #1;
      reset      = 1'b1;
      IF_valid   = 1'b0;
      next_fetch = 1'b0;
      jbr_bus    = '0;
      exc_bus    = '0;
      axi_done   = 1'b0;
      axi_busy   = 1'b0;
      #1;
      n_checks++;
      if (axi_start !== 1'b0 || axi_addr !== START || IF_over !== 1'b0 || IF_ID_bus !== 64'h0 || q_count !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_values: start=%b addr=%h over=%b bus=%h count=%0d", axi_start, axi_addr, IF_over,
                  IF_ID_bus, q_count);
      end
`ifdef FETCH_PERF_EN
      n_checks++;
      if (perf_fetched !== 32'd0 || perf_flushed !== 32'd0 || perf_empty_stall !== 32'd0) begin
         n_fail++;
         $display("FAIL perf_reset: got %0d/%0d/%0d expected 0/0/0", perf_fetched, perf_flushed, perf_empty_stall);
      end
      exp_fetched = '0;
      exp_flushed = '0;
      exp_stall   = '0;
`endif
      mq.delete();
      exp_pc   = START;
      out_live = 1'b0;
      sl_pend  = 1'b0;
      sl_tail  = 0;
      d_valid  = 1'b0;
      d_next   = 1'b0;
      d_busy   = 1'b0;
      d_jbr    = '0;
      d_exc    = '0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      step();
      n_checks++;
      if (axi_start !== 1'b0 || IF_over !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: start=%b over=%b expected 0/0", axi_start, IF_over);
      end
   endtask

   task automatic test_fill();
      lat     = 2;
      d_valid = 1'b1;
      d_next  = 1'b0;
      addr_log.delete();
      n_starts = 0;
      repeat (40) step();
      n_checks++;
      if (n_starts != 4) begin
         n_fail++;
         $display("FAIL fill_requests: got %0d expected 4", n_starts);
      end
      for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
         n_checks++;
         if (addr_log[i] !== 32'(4 * i)) begin
            n_fail++;
            $display("FAIL fill_addr%0d: got %h expected %h", i, addr_log[i], 32'(4 * i));
         end
      end
      n_checks++;
      if (q_count !== 3'd4 || IF_ID_bus !== {32'h0, KEY}) begin
         n_fail++;
         $display("FAIL fill_head: count=%0d bus=%h expected 4 and %h", q_count, IF_ID_bus, {32'h0, KEY});
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pops[$];
      int          qlow  = -1;
      int          first = -1;
      int          early = 0;
      d_next = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (IF_over && d_next) begin
            pops.push_back(IF_pc);
            if (i < 4) early++;
         end
         if (qlow < 0 && q_count < 3'd4) qlow = i;
         if (first < 0 && s_start) first = i;
      end
      n_checks++;
      if (early != 4) begin
         n_fail++;
         $display("FAIL pop_rate: got %0d pops in 4 cycles expected 4", early);
      end
      for (int i = 0; i < 4 && i < pops.size(); i++) begin
         n_checks++;
         if (pops[i] !== 32'(4 * i)) begin
            n_fail++;
            $display("FAIL pop_order%0d: got %h expected %h", i, pops[i], 32'(4 * i));
         end
      end
      n_checks++;
      if (qlow < 0 || first != qlow + 1) begin
         n_fail++;
         $display("FAIL refill_issue: start cycle %0d expected %0d", first, qlow + 1);
      end
   endtask

   task automatic test_branch_flush();
      bit found = 0;
      do_reset();
      lat     = 3;
      d_valid = 1'b1;
      d_next  = 1'b1;
      for (int i = 0; i < TMO && !found; i++) begin
         step();
         found = s_start && (s_addr == 32'h10);
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL branch_setup: no request for pc 0x10 within %0d cycles", TMO);
      end
      d_jbr = {1'b1, 32'h100};
      step();
      d_jbr = '0;
      found = 0;
      for (int i = 0; i < TMO && !found; i++) begin
         step();
         found = s_done;
      end
      step();
      n_checks++;
      if (!found || IF_over !== 1'b0 || q_count !== 3'd0) begin
         n_fail++;
         $display("FAIL branch_drop: done=%b over=%b count=%0d expected 1/0/0", found, IF_over, q_count);
      end
      found = s_start;
      for (int i = 0; i < TMO && !found; i++) begin
         step();
         found = s_start;
      end
      n_checks++;
      if (!found || s_addr !== 32'h100) begin
         n_fail++;
         $display("FAIL branch_target: axi_addr=%h expected %h", s_addr, 32'h100);
      end
      found = 0;
      for (int i = 0; i < TMO && !found; i++) begin
         step();
         found = IF_over;
      end
      n_checks++;
      if (!found || IF_pc !== 32'h100) begin
         n_fail++;
         $display("FAIL branch_first_pc: IF_pc=%h expected %h", IF_pc, 32'h100);
      end
   endtask

   task automatic test_exc_priority();
      bit found = 0;
      lat     = 2;
      d_valid = 1'b1;
      d_next  = 1'b0;
      for (int i = 0; i < TMO && !found; i++) begin
         step();
         found = sl_pend && (sl_rem == 1);
      end
      d_exc = {1'b1, 32'h180};
      d_jbr = {1'b1, 32'h200};
      step();
      d_exc = '0;
      d_jbr = '0;
      n_checks++;
      if (!found || !s_done) begin
         n_fail++;
         $display("FAIL exc_setup: done_with_redirect=%b expected 1", s_done);
      end
      found = 0;
      for (int i = 0; i < TMO && !found; i++) begin
         step();
         found = s_start;
      end
      n_checks++;
      if (!found || s_addr !== 32'h180) begin
         n_fail++;
         $display("FAIL exc_target: axi_addr=%h expected %h", s_addr, 32'h180);
      end
      found = 0;
      for (int i = 0; i < TMO && !found; i++) begin
         step();
         found = IF_over;
      end
      n_checks++;
      if (!found || IF_pc !== 32'h180) begin
         n_fail++;
         $display("FAIL exc_discard_clear: IF_pc=%h over=%b expected %h/1", IF_pc, found, 32'h180);
      end
   endtask

   task automatic test_busy();
      do_reset();
      lat     = 2;
      d_busy  = 1'b1;
      step();
      d_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (s_start !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_hold%0d: axi_start=%b expected 0", i, s_start);
         end
      end
      d_busy = 1'b0;
      step();
      n_checks++;
      if (s_start !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_fall: axi_start=%b expected 0", s_start);
      end
      step();
      n_checks++;
      if (s_start !== 1'b1 || s_addr !== START) begin
         n_fail++;
         $display("FAIL busy_release: start=%b addr=%h expected 1/%h", s_start, s_addr, START);
      end
   endtask

   task automatic test_reset_mid();
      bit found = 0;
      do_reset();
      lat     = 3;
      d_valid = 1'b1;
      d_next  = 1'b0;
      for (int i = 0; i < TMO && !found; i++) begin
         step();
         found = (q_count == 3'd2) && sl_pend;
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL reset_mid_setup: count=%0d pending=%b expected 2/1", q_count, sl_pend);
      end
      do_reset();
      d_valid = 1'b1;
      found   = 0;
      for (int i = 0; i < TMO && !found; i++) begin
         step();
         found = s_start;
      end
      n_checks++;
      if (!found || s_addr !== START) begin
         n_fail++;
         $display("FAIL reset_restart: axi_addr=%h expected %h", s_addr, START);
      end
   endtask

   task automatic test_wrap();
      lat     = 1;
      d_valid = 1'b1;
      d_next  = 1'b1;
      d_jbr   = {1'b1, 32'hFFFF_FFF8};
      step();
      d_jbr = '0;
      addr_log.delete();
      for (int i = 0; i < TMO && addr_log.size() < 3; i++) step();
      n_checks++;
      if (addr_log.size() < 3 || addr_log[2] !== 32'h0) begin
         n_fail++;
         $display("FAIL pc_wrap: got %0d requests, third addr %h expected 0",
                  addr_log.size(), addr_log.size() >= 3 ? addr_log[2] : 32'hx);
      end
   endtask

   task automatic test_random();
      rand_tail = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         d_valid = ($urandom_range(0, 7) != 0);
         d_next  = $urandom_range(0, 1) != 0;
         lat     = $urandom_range(1, 3);
         d_jbr   = '0;
         d_exc   = '0;
         case ($urandom_range(0, 31))
            0:       d_jbr = {1'b1, $urandom() & 32'hFFFF_FFFC};
            1:       d_exc = {1'b1, $urandom() & 32'hFFFF_FFFC};
            2: begin
               d_jbr = {1'b1, $urandom() & 32'hFFFF_FFFC};
               d_exc = {1'b1, $urandom() & 32'hFFFF_FFFC};
            end
            default: ;
         endcase
         step();
      end
      d_jbr     = '0;
      d_exc     = '0;
      rand_tail = 1'b0;
      repeat (10) step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
`ifdef FETCH_PERF_EN
      exp_fetched = '0;
      exp_flushed = '0;
      exp_stall   = '0;
`endif
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_fill();
      test_back_to_back();
      test_branch_flush();
      test_exc_priority();
      test_busy();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
